// File: rtl/mac_ifmaps_multirow_fifo.sv
// Multi-row ifmaps FIFO: NUM_ROWS x DATA_WIDTH lanes per entry, with occupancy and almost-full status; optional sticky error flags under MAC_IFMAPS_FIFO_ERR_FLAGS_EN.
// Latency: a write is readable one edge later; read data and its valid pulse are registered, so they appear one edge after fifo_read.
// Backpressure: a write while full is dropped unless a read is accepted on the same edge; a read while empty is dropped.
module mac_ifmaps_multirow_fifo #(
    parameter int DATA_WIDTH         = 1,
    parameter int NUM_ROWS           = 5,
    parameter int DEPTH              = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1,
    parameter int CNT_W              = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] ifmaps_fifo_in,
    input  logic                           ifmaps_input_valid,
    input  logic                           fifo_read,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] ifmaps_fifo_out,
    output logic                           ifmaps_output_valid,
    output logic                           fifo_full,
    output logic                           fifo_empty,
    output logic                           fifo_almost_full,
    output logic [CNT_W-1:0]               fifo_count,
    output logic                           fifo_overflow,
    output logic                           fifo_underflow
);

    localparam int W     = NUM_ROWS * DATA_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             rd_acc;
    logic             wr_acc;

    // Explicit wrap keeps non-power-of-two depths legal.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full        = (count == FULL_CNT);
    assign fifo_empty       = (count == '0);
    assign fifo_almost_full = (count >= AF_CNT);
    assign fifo_count       = count;

    // No bypass: a read against an empty FIFO is rejected even if a write lands on the same edge.
    assign rd_acc = fifo_read & ~fifo_empty;
    assign wr_acc = ifmaps_input_valid & (~fifo_full | rd_acc);

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= ifmaps_fifo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            ifmaps_fifo_out     <= '0;
            ifmaps_output_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr          <= next_ptr(rd_ptr);
                ifmaps_fifo_out <= mem[rd_ptr];
            end
            ifmaps_output_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MAC_IFMAPS_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ifmaps_input_valid & ~wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (fifo_read & fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;
`else
    assign fifo_overflow  = 1'b0;
    assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_mac_ifmaps_multirow_fifo.sv
// Bench for mac_ifmaps_multirow_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_mac_ifmaps_multirow_fifo;

    localparam int DW    = 1;
    localparam int NR    = 5;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] din;
    logic          wr;
    logic          rd;
    logic [NR-1:0] dout;
    logic          dvld;
    logic          full;
    logic          empty;
    logic          afull;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [NR-1:0] q[$];
    logic [NR-1:0] m_out;
    logic          m_vld;
    logic          m_ovf;
    logic          m_unf;

`ifdef MAC_IFMAPS_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mac_ifmaps_multirow_fifo #(
        .DATA_WIDTH(DW), .NUM_ROWS(NR), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifmaps_fifo_in(din), .ifmaps_input_valid(wr),
        .fifo_read(rd), .ifmaps_fifo_out(dout), .ifmaps_output_valid(dvld),
        .fifo_full(full), .fifo_empty(empty), .fifo_almost_full(afull), .fifo_count(cnt),
        .fifo_overflow(ovf), .fifo_underflow(unf)
    );

    // Bit string "r0 r1 r2 r3 r4" -> packed vector with row r at bit r.
    function automatic logic [NR-1:0] rows(input string s);
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = (s[i] == "1");
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        check({tag, ":count"}, 32'(cnt), 32'(sz));
        check({tag, ":empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ":full"},  32'(full),  32'(sz == DEPTH));
        check({tag, ":afull"}, 32'(afull), 32'(sz >= AFT));
        check({tag, ":vld"},   32'(dvld),  32'(m_vld));
        check({tag, ":out"},   32'(dout),  32'(m_out));
        check({tag, ":ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ":unf"},   32'(unf),   32'(m_unf));
    endtask

    // One clock edge with the given request pattern; the model is advanced and outputs compared after the edge.
    task automatic cyc(input logic r_n, input logic w, input logic [NR-1:0] d, input logic r,
                       input string tag);
        bit rd_ok, wr_ok;
        rst_n = r_n; wr = w; din = d; rd = r;
        @(posedge clk);
        if (!r_n) begin
            q.delete();
            m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (ERR_EN && w && !wr_ok) m_ovf = 1'b1;
            if (ERR_EN && r && q.size() == 0) m_unf = 1'b1;
            m_vld = rd_ok;
            if (rd_ok) m_out = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic wr1(input string s); cyc(1'b1, 1'b1, rows(s), 1'b0, {"wr_", s}); endtask
    task automatic rd1(input string tag); cyc(1'b1, 1'b0, '0, 1'b1, tag); endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #2;
        cyc(1'b0, 1'b0, '0, 1'b0, "reset0");
        cyc(1'b0, 1'b1, 5'h1f, 1'b1, "reset1");
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_out",   32'(dout),  32'd0);

        // Fill and overflow
        wr1("01010"); wr1("11111");
        wr1("00101"); check("fill3_afull", 32'(afull), 32'd1); check("fill3_full", 32'(full), 32'd0);
        wr1("10110"); check("fill4_full",  32'(full),  32'd1);
        wr1("01000"); check("ovf_count", 32'(cnt), 32'd4); check("ovf_flag", 32'(ovf), 32'(ERR_EN));

        // Read order
        rd1("rd0"); check("rd0_data", 32'(dout), 32'(rows("01010"))); check("rd0_vld", 32'(dvld), 32'd1);
        rd1("rd1"); check("rd1_data", 32'(dout), 32'(rows("11111")));
        rd1("rd2"); check("rd2_data", 32'(dout), 32'(rows("00101")));
        cyc(1'b1, 1'b0, '0, 1'b0, "idle"); check("vld_pulse", 32'(dvld), 32'd0);
        check("rd_count", 32'(cnt), 32'd1);

        // Full exchange
        cyc(1'b0, 1'b0, '0, 1'b0, "reset2");
        wr1("11111"); wr1("00101"); wr1("10110"); wr1("00011");
        cyc(1'b1, 1'b1, rows("10000"), 1'b1, "xchg");
        check("xchg_data", 32'(dout), 32'(rows("11111"))); check("xchg_count", 32'(cnt), 32'd4);
        rd1("x0"); check("x0_data", 32'(dout), 32'(rows("00101")));
        rd1("x1"); check("x1_data", 32'(dout), 32'(rows("10110")));
        rd1("x2"); check("x2_data", 32'(dout), 32'(rows("00011")));
        rd1("x3"); check("x3_data", 32'(dout), 32'(rows("10000")));

        // Empty boundary
        cyc(1'b1, 1'b1, rows("00110"), 1'b1, "empty_wr_rd");
        check("eb_vld", 32'(dvld), 32'd0); check("eb_count", 32'(cnt), 32'd1);
        rd1("eb_rd"); check("eb_data", 32'(dout), 32'(rows("00110")));
        rd1("eb_under");
        check("eb_unf", 32'(unf), 32'(ERR_EN)); check("eb_hold", 32'(dout), 32'(rows("00110")));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            cyc(($urandom_range(0, 99) != 0), w, NR'($urandom), r, "rand");
        end

        // Mid-run reset with count 3, then pointer wrap
        cyc(1'b0, 1'b0, '0, 1'b0, "reset3");
        wr1("10001"); wr1("01110"); wr1("11000");
        check("pre_reset_count", 32'(cnt), 32'd3);
        cyc(1'b0, 1'b1, rows("11111"), 1'b1, "midreset");
        check("mr_count", 32'(cnt), 32'd0); check("mr_empty", 32'(empty), 32'd1);
        check("mr_out", 32'(dout), 32'd0); check("mr_ovf", 32'(ovf), 32'd0); check("mr_unf", 32'(unf), 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic [NR-1:0] v;
            v = NR'(i * 7 + 3);
            cyc(1'b1, 1'b1, v, 1'b0, "wrap_wr");
            cyc(1'b1, 1'b0, '0, 1'b1, "wrap_rd");
            check("wrap_data", 32'(dout), 32'(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_ifmaps_multirow_fifo.md
# mac_ifmaps_multirow_fifo

Parametrised multi-row input-feature-map FIFO feeding the MAC array. Each entry holds one column slice: NUM_ROWS lanes of DATA_WIDTH bits, written together under a valid strobe and read together under a read strobe. This block generalises the fixed 5-row, 1-bit ifmaps FIFO with:
- configurable row count, width and depth;
- an occupancy count and almost-full flag;
- a registered output-valid strobe;
- optional sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 1, bits per row lane
- NUM_ROWS, 5, number of row lanes per entry
- DEPTH, 4, number of entries; any integer ≥ 2
- ALMOST_FULL_THRESH, DEPTH-1, count at or above which almost_full asserts; legal range 1..DEPTH
- CNT_W, $clog2(DEPTH+1), width of fifo_count

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  rising-edge clock
  - rst_n  in  1  synchronous active-low reset
- Write side:
  - ifmaps_fifo_in  in  NUM_ROWS*DATA_WIDTH  row r occupies bits [r*DATA_WIDTH +: DATA_WIDTH]
  - ifmaps_input_valid  in  1  write request
- Read side:
  - fifo_read  in  1  read request
  - ifmaps_fifo_out  out  NUM_ROWS*DATA_WIDTH  registered read data, same lane packing as ifmaps_fifo_in
  - ifmaps_output_valid  out  1  one-cycle pulse; ifmaps_fifo_out is new this cycle
- Status:
  - fifo_full  out  1  count == DEPTH
  - fifo_empty  out  1  count == 0
  - fifo_almost_full  out  1  count ≥ ALMOST_FULL_THRESH
  - fifo_count  out  CNT_W  current occupancy
- Errors:
  - fifo_overflow  out  1  sticky rejected-write flag; see Configuration
  - fifo_underflow  out  1  sticky rejected-read flag; see Configuration

## Operation
- Storage: DEPTH × (NUM_ROWS*DATA_WIDTH) register array.
- Pointers: wr_ptr and rd_ptr, each wrapping from DEPTH-1 to 0. The wrap is explicit, so non-power-of-two DEPTH is legal.
- Read accept: rd_acc = fifo_read & ~fifo_empty.
- Write accept: wr_acc = ifmaps_input_valid & (~fifo_full | rd_acc).
  - A write while full is accepted only when a read is accepted on the same edge.
- Simultaneous events:
  - Read and write on the same edge while full: both accepted, count unchanged.
  - Read and write on the same edge while empty: write accepted, read rejected. There is no bypass, and ifmaps_output_valid stays 0.
  - Read and write on the same edge otherwise: both accepted, count unchanged.
- Count update: count += wr_acc − rd_acc.
- Flags: fifo_full, fifo_empty and fifo_almost_full are decoded from the count register, so they reflect state after the last edge.
- On rd_acc:
  - ifmaps_fifo_out ← mem[rd_ptr];
  - ifmaps_output_valid ← 1.
- Otherwise ifmaps_output_valid ← 0 and ifmaps_fifo_out holds its last value.
- Rejected requests change no pointer, no count and no memory.
- Reset (rst_n low at an edge) clears:
  - pointers and count to 0;
  - ifmaps_fifo_out to 0, ifmaps_output_valid to 0;
  - fifo_empty to 1, fifo_full to 0, fifo_almost_full to 0;
  - error flags to 0.
  - Memory contents are not cleared.
- Mid-operation reset discards all entries; any request in the reset cycle is ignored.

## Timing
- Write-to-readable latency: 1 edge. Data written at edge N makes fifo_empty 0 after N and can be read at edge N+1.
- Read latency: 1 edge. fifo_read high before edge N puts the data on ifmaps_fifo_out after N, with ifmaps_output_valid high for exactly that cycle.
- Back-to-back reads every cycle produce one entry per cycle until empty.
- Throughput: one write and one read per cycle.
- Inputs are sampled on the rising edge only. Request signals may be held for multiple cycles; each edge with the request high counts as a separate request.

## Configuration
Macro: MAC_IFMAPS_FIFO_ERR_FLAGS_EN.
- Defined:
  - fifo_overflow sets when ifmaps_input_valid & ~wr_acc.
  - fifo_underflow sets when fifo_read & fifo_empty.
  - Both are sticky until reset.
- Not defined: both ports are tied to 0 and no flag registers exist. The port list is identical in both builds.

## Test plan
All scenarios use NUM_ROWS=5, DATA_WIDTH=1, DEPTH=4, ALMOST_FULL_THRESH=3. Entries are written as the bit string for rows 0..4 (e.g. 01010 = row0 0, row1 1, row2 0, row3 1, row4 0).
- Fill: write 01010, 11111, 00101, 10110 → count steps 1,2,3,4. almost_full asserts at 3, full at 4.
- Overflow: a 5th write of 01000 while full → rejected, count stays 4. fifo_overflow=1 with the macro, 0 without.
- Read order: three reads after Fill → outputs 01010, 11111, 00101, each with a one-cycle ifmaps_output_valid. Count ends at 1.
- Full exchange: with the FIFO full (11111, 00101, 10110, 00011), a simultaneous write 10000 and read on one edge → output 11111, count stays 4. A further four reads return 00101, 10110, 00011, 10000.
- Empty boundary: simultaneous write 00110 and read while empty → ifmaps_output_valid stays 0 and count becomes 1. The next read returns 00110. A subsequent read while empty → fifo_underflow=1 with the macro, and ifmaps_fifo_out holds 00110.
- Mid-run reset: rst_n low for one edge with count 3 → count 0, fifo_empty 1, ifmaps_fifo_out 0, error flags 0. Pointer wrap is confirmed by 10 write/read pairs returning data in order.
